tone_gen: RTL

Parametrised square-wave tone generator for the tone-organ datapath. A note index, plus an optional octave shift, selects a half-period count from a shared note table. A free-running divider toggles `tone_out` at that rate. Note changes are deferred to the next half-period boundary so the audio output never carries a runt pulse. It sits between the switch/keypad decode and the audio/LED output stage, all in the 50 MHz domain.

---
 rtl/tone_pkg.sv | 19 +
 rtl/note_rom.sv | 36 +++
 rtl/tone_gen.sv | 85 ++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared constants for the tone generator: default sizes, the C5..C6
// half-period table (50 MHz cycles) and the smallest usable half-period.
package tone_pkg;

  localparam int NOTES_DEF = 8;
  localparam int CNT_W_DEF = 32;
  localparam int OCT_W_DEF = 2;

  // A half-period below 2 cycles would make the divider toggle every cycle
  // with no room for the boundary logic, so shifted counts never go below it.
  localparam int unsigned MIN_COUNT = 2;

  // Entry 0 is C5 (523 Hz) up to entry 7, C6 (1046 Hz).
  localparam logic [0:NOTES_DEF-1][CNT_W_DEF-1:0] NOTE_TABLE = '{
    32'h0000_BAB9, 32'h0000_A65D, 32'h0000_9430, 32'h0000_8BE9,
    32'h0000_7CB8, 32'h0000_6EF9, 32'h0000_62F1, 32'h0000_5D5D
  };

endpackage

// File: rtl/note_rom.sv
// Index-to-half-period lookup for the tone generator.
// Optional octave shift and minimum-count clamp are built only when
// TONE_GEN_OCTAVE_EN is defined; otherwise the octave input is ignored.
module note_rom
  import tone_pkg::*;
#(
  parameter int NOTES = NOTES_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int OCT_W = OCT_W_DEF,
  parameter logic [0:NOTES-1][CNT_W-1:0] TABLE = tone_pkg::NOTE_TABLE,
  localparam int SEL_W = $clog2(NOTES)
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [OCT_W-1:0] octave,
  output logic [CNT_W-1:0] count
);

`ifdef TONE_GEN_OCTAVE_EN
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_COUNT);

  // Saturate short half-periods up to the minimum the divider can run at.
  function automatic logic [CNT_W-1:0] clamp_min(input logic [CNT_W-1:0] value);
    return (value < MIN_CNT) ? MIN_CNT : value;
  endfunction

  // Each octave step halves the half-period, i.e. doubles the pitch.
  always_comb count = clamp_min(TABLE[sel] >> octave);
`else
  logic unused_octave;
  assign unused_octave = ^octave;

  // Plain table lookup; octave has no effect in this build.
  always_comb count = TABLE[sel];
`endif

endmodule

// File: rtl/tone_gen.sv
// Square-wave tone generator: note requests are held in a pending register
// and applied only at a half-period boundary (or at once while idle), so
// tone_out never carries a runt pulse. All outputs are registered.
// Build option: TONE_GEN_OCTAVE_EN enables the octave shift in note_rom.
module tone_gen
  import tone_pkg::*;
#(
  parameter int NOTES = NOTES_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int OCT_W = OCT_W_DEF,
  parameter logic [0:NOTES-1][CNT_W-1:0] TABLE = tone_pkg::NOTE_TABLE,
  localparam int SEL_W = $clog2(NOTES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             note_valid,
  input  logic [SEL_W-1:0] note_sel,
  input  logic [OCT_W-1:0] octave,
  output logic             tone_out,
  output logic             edge_tick,
  output logic             pending,
  output logic [CNT_W-1:0] active_count
);

  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] pend_count;
  logic [CNT_W-1:0] cnt;
  logic             at_end;

  note_rom #(
    .NOTES (NOTES),
    .CNT_W (CNT_W),
    .OCT_W (OCT_W),
    .TABLE (TABLE)
  ) u_note_rom (
    .sel    (note_sel),
    .octave (octave),
    .count  (target)
  );

  // Last cycle of the current half-period.
  always_comb at_end = (cnt == active_count - CNT_W'(1));

  // Pending count is pure data: only the pending flag decides if it is used.
  always_ff @(posedge clk) begin
    if (note_valid) pend_count <= target;
  end

  // Divider, boundary-aligned note switch and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      tone_out     <= 1'b0;
      edge_tick    <= 1'b0;
      pending      <= 1'b0;
      active_count <= TABLE[0];
    end else begin
      edge_tick <= 1'b0;
      if (!enable) begin
        // Idle: nothing audible to protect, so apply a queued note right away.
        cnt      <= '0;
        tone_out <= 1'b0;
        if (pending) begin
          active_count <= pend_count;
          pending      <= 1'b0;
        end
      end else if (at_end) begin
        cnt       <= '0;
        tone_out  <= ~tone_out;
        edge_tick <= 1'b1;
        if (pending) begin
          active_count <= pend_count;
          pending      <= 1'b0;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // A request arriving on a boundary is only queued; it waits for the
      // next boundary. The latest request always wins.
      if (note_valid) pending <= 1'b1;
    end
  end

endmodule
